// File: rtl/chip_emu_pkg.sv
// chip_emu_pkg: shared instruction/state types and array geometry for chip_emu
package chip_emu_pkg;

    localparam int NRow = 32;
    localparam int NCol = 8;

    typedef enum logic [1:0] {
        INSTR_INFER  = 2'b00,
        INSTR_RD_REG = 2'b01,
        INSTR_RD_MEM = 2'b10,
        INSTR_PROG   = 2'b11
    } instr_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROG,
        ST_RD_WAIT,
        ST_INFER
    } state_e;

endpackage

// File: rtl/chip_emu_bank.sv
// chip_emu_bank: one 32x8 single-bit cell bank, shared write/read address, combinational read
//   clk_i/rst_ni : clock, async active-low reset (clears every cell)
//   we_i, d_i    : write enable and data for cell [row_i][col_i]
//   q_o          : current content of cell [row_i][col_i]
module chip_emu_bank
    import chip_emu_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [$clog2(NRow)-1:0]   row_i,
    input  logic [$clog2(NCol)-1:0]   col_i,
    input  logic                      d_i,
    output logic                      q_o
);

    logic [NRow-1:0][NCol-1:0] cells_q, cells_d;

    always_comb begin
        cells_d = cells_q;
        if (we_i) cells_d[row_i][col_i] = d_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cells_q <= '0;
        else         cells_q <= cells_d;
    end

    assign q_o = cells_q[row_i][col_i];

endmodule

// File: rtl/chip_emu.sv
// chip_emu: strobe-driven emulator of a 4-bank 1-bit cell array with program, read and AND-inference
//   clk_i/rst_ni       : clock, async active-low reset
//   CSL                : strobe; an operation starts on its rising edge while idle
//   instructions       : 11 prog, 10 read_mem, 01 read_reg, 00 inference
//   CBL/CBLEN/CWL      : program data, program enable, write line
//   adr_full_col/_row  : [4:3] bank, [2:0] column / row 0..31
//   DATA_out           : registered read result, one bit per bank
//   err_o              : sticky protocol error flag, present only with CHIP_EMU_ERR_EN
module chip_emu
    import chip_emu_pkg::*;
#(
    parameter int ReadLat = 2,
    parameter int NArray  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              CBL,
    input  logic              CBLEN,
    input  logic              CSL,
    input  logic              CWL,
    input  logic [1:0]        instructions,
    input  logic [4:0]        adr_full_col,
    input  logic [4:0]        adr_full_row,
    output logic [NArray-1:0] DATA_out
`ifdef CHIP_EMU_ERR_EN
    ,
    output logic              err_o
`endif
);

    state_e             state_q, state_d;
    instr_e             instr_q, instr_d;
    logic [4:0]         row_q, row_d, col_q, col_d;
    logic               cbl_q, cbl_d, we_q, we_d, csl_q, csl_d, chain_q, chain_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [NArray-1:0]  acc_q, acc_d, data_q, data_d, cell_rd;
    logic               wr_en, strobe, abort;

    assign strobe = CSL && !csl_q;
    // a read is abandoned as soon as the instruction bus stops matching the captured opcode
    assign abort  = state_q == ST_RD_WAIT && instructions != instr_q;

    for (genvar i = 0; i < NArray; i++) begin : g_bank
        chip_emu_bank u_bank (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .we_i  (wr_en && col_q[4:3] == 2'(i)),
            .row_i (row_q),
            .col_i (col_q[2:0]),
            .d_i   (cbl_q),
            .q_o   (cell_rd[i])
        );
    end

    always_comb begin
        csl_d   = CSL;
        state_d = state_q;
        instr_d = instr_q;
        row_d   = row_q;
        col_d   = col_q;
        cbl_d   = cbl_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        chain_d = chain_q;
        data_d  = data_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: if (strobe) begin
                instr_d = instr_e'(instructions);
                row_d   = adr_full_row;
                col_d   = adr_full_col;
                cbl_d   = CBL;
                we_d    = CWL && CBLEN;
                cnt_d   = 3'd1;
                // any non-inference operation restarts the accumulation chain
                chain_d = chain_q && instructions == INSTR_INFER;
                state_d = instructions == INSTR_PROG  ? ST_PROG :
                          instructions == INSTR_INFER ? ST_INFER : ST_RD_WAIT;
            end
            ST_PROG: begin
                wr_en   = we_q;
                state_d = ST_IDLE;
            end
            ST_INFER: begin
                acc_d   = chain_q ? acc_q & cell_rd : cell_rd;
                chain_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 3'(ReadLat)) begin
                    data_d  = instr_q == INSTR_RD_MEM ? cell_rd : acc_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            instr_q <= INSTR_INFER;
            row_q   <= '0;
            col_q   <= '0;
            cbl_q   <= 1'b0;
            we_q    <= 1'b0;
            csl_q   <= 1'b0;
            chain_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cbl_q   <= cbl_d;
            we_q    <= we_d;
            csl_q   <= csl_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
        end
    end

    assign DATA_out = data_q;

`ifdef CHIP_EMU_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || abort || (strobe && state_q != ST_IDLE) ||
                (strobe && state_q == ST_IDLE && instructions == INSTR_PROG && CWL && !CBLEN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_chip_emu.sv
// tb_chip_emu: scoreboard bench for chip_emu; reads queue their expected DATA_out with a due cycle
module tb_chip_emu;
    parameter int LAT = 2;

    typedef struct {
        int         due;
        logic [3:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0, rst_ni = 1'b0;
    logic       CBL = 1'b0, CBLEN = 1'b0, CSL = 1'b0, CWL = 1'b0;
    logic [1:0] instructions = 2'b00;
    logic [4:0] adr_full_col = '0, adr_full_row = '0;
    logic [3:0] DATA_out;
`ifdef CHIP_EMU_ERR_EN
    logic       err_o;
`endif

    int         cyc = 0, n_chk = 0, n_fail = 0;
    exp_t       q[$];
    logic [3:0] data_exp = 4'b0000;

    chip_emu #(.ReadLat(LAT), .NArray(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .CBL         (CBL),
        .CBLEN       (CBLEN),
        .CSL         (CSL),
        .CWL         (CWL),
        .instructions(instructions),
        .adr_full_col(adr_full_col),
        .adr_full_row(adr_full_row),
        .DATA_out    (DATA_out)
`ifdef CHIP_EMU_ERR_EN
        ,
        .err_o       (err_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [3:0] act, input logic [3:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", n, act, want, cyc);
        end
    endtask

    // monitor: DATA_out is compared against every queued expectation on its due cycle
    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due != cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: check due at cycle %0d reached only at %0d", e.name, e.due, cyc);
            end else begin
                chk(e.name, DATA_out, e.val);
            end
        end
    end

    task automatic strobe(input logic [1:0] ins, input logic [4:0] row, input logic [4:0] col,
                          input logic cbl, input logic cblen, input logic cwl, output int s);
        @(negedge clk);
        instructions = ins;
        adr_full_row = row;
        adr_full_col = col;
        CBL = cbl;
        CBLEN = cblen;
        CWL = cwl;
        CSL = 1'b1;
        @(posedge clk);
        #1 s = cyc;
    endtask

    task automatic prog(input logic [4:0] row, input logic [4:0] col, input logic cbl, input logic cblen);
        int s;
        strobe(2'b11, row, col, cbl, cblen, 1'b1, s);
        @(negedge clk);
        CSL = 1'b0;
    endtask

    task automatic infer(input logic [4:0] row, input logic [4:0] col);
        int s;
        strobe(2'b00, row, col, 1'b0, 1'b0, 1'b0, s);
        @(negedge clk);
        CSL = 1'b0;
    endtask

    // DATA_out must hold its old value one cycle before the read lands, then show the new one
    task automatic rd(input logic [1:0] ins, input logic [4:0] row, input logic [4:0] col,
                      input logic [3:0] want, input string n);
        int s;
        strobe(ins, row, col, 1'b0, 1'b0, 1'b0, s);
        q.push_back('{s + LAT - 1, data_exp, {n, "_hold"}});
        q.push_back('{s + LAT, want, n});
        data_exp = want;
        @(negedge clk);
        CSL = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int s;
        logic [4:0] c;
        repeat (3) @(negedge clk);
        chk("reset_data", DATA_out, 4'b0000);
`ifdef CHIP_EMU_ERR_EN
        chk("reset_err", {3'b000, err_o}, 4'b0000);
`endif
        rst_ni = 1'b1;

        prog(5'd5, 5'b10011, 1'b1, 1'b1);
        rd(2'b10, 5'd5, 5'b10011, 4'b0100, "rd_b2r5c3");

        prog(5'd7, 5'b01101, 1'b1, 1'b0);
        rd(2'b10, 5'd7, 5'b01101, 4'b0000, "rd_no_cblen");
`ifdef CHIP_EMU_ERR_EN
        chk("err_no_cblen", {3'b000, err_o}, 4'b0001);
`endif

        for (int b = 0; b < 4; b++) begin
            prog(5'd1, {2'(b), 3'd0}, 1'b1, 1'b1);
            prog(5'd2, {2'(b), 3'd0}, 1'b1, 1'b1);
        end
        prog(5'd2, 5'b00000, 1'b0, 1'b1);
        rd(2'b10, 5'd2, 5'd0, 4'b1110, "rd_r2c0");
        infer(5'd1, 5'd0);
        infer(5'd2, 5'd0);
        rd(2'b01, 5'd0, 5'd0, 4'b1110, "rdreg_and");

        rd(2'b10, 5'd1, 5'd0, 4'b1111, "rd_r1c0");
        infer(5'd1, 5'd0);
        rd(2'b01, 5'd0, 5'd0, 4'b1111, "rdreg_reload");
        infer(5'd1, 5'd0);
        infer(5'd5, 5'b00011);
        rd(2'b01, 5'd0, 5'd0, 4'b0100, "rdreg_chain");

        strobe(2'b10, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, s);
        @(negedge clk);
        CSL = 1'b0;
        instructions = 2'b01;
        q.push_back('{s + LAT, data_exp, "abort_hold"});
        q.push_back('{s + LAT + 1, data_exp, "abort_hold_late"});
        repeat (LAT + 1) @(negedge clk);
`ifdef CHIP_EMU_ERR_EN
        chk("err_abort", {3'b000, err_o}, 4'b0001);
`endif
        rd(2'b10, 5'd1, 5'd0, 4'b1111, "rd_after_abort");

        for (int k = 0; k < 8; k++) prog(5'd10, {2'(k), 3'(k)}, 1'b1, 1'b1);
        rd(2'b10, 5'd10, 5'd5, 4'b0010, "rd_r10c5");

        strobe(2'b11, 5'd20, 5'b11111, 1'b1, 1'b1, 1'b1, s);
        #2 rst_ni = 1'b0;
        #1 chk("reset_async_data", DATA_out, 4'b0000);
`ifdef CHIP_EMU_ERR_EN
        chk("reset_async_err", {3'b000, err_o}, 4'b0000);
`endif
        CSL = 1'b0;
        data_exp = 4'b0000;
        @(negedge clk);
        rst_ni = 1'b1;

        rd(2'b10, 5'd20, 5'b11111, 4'b0000, "rd_discarded_prog");
        for (int j = 0; j < 8; j++) begin
            c = {2'(j), 3'(j)};
            rd(2'b10, 5'd10, c, 4'b0000, $sformatf("rd_cleared_r10c%0d", j));
        end
        rd(2'b10, 5'd1, 5'd0, 4'b0000, "rd_cleared_r1c0");
        rd(2'b01, 5'd0, 5'd0, 4'b0000, "rdreg_cleared");

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d checks still pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
